// File: rtl/rv32im_lsu_ctrl.sv
// rv32im_lsu_ctrl: sequences EXU load/store requests onto a single-port data bus.
// Builds the word address, byte enables and lane-replicated store data, and checks
// alignment. It then runs the request/grant/response handshake with a response
// timeout, and returns one extended load result plus a done pulse per request.
//
// Opcode encoding on lsu_opcode_i (bit 3 = store, bit 2 = unsigned, [1:0] = size):
//   LB=4'h0 LH=4'h1 LW=4'h2 LBU=4'h4 LHU=4'h5 SB=4'h8 SH=4'h9 SW=4'hA; others illegal.
// rdata, misalign and buserr are updated only on entry to DONE. They then hold until
// the next DONE. Errored accesses and stores return rdata 0.
module rv32im_lsu_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned OP_W          = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lsu_req_i,
    input  logic [OP_W-1:0]       lsu_opcode_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_done_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_misalign_o,
    output logic                  lsu_buserr_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [OP_W-1:0] OP_LB  = 4'h0;
    localparam logic [OP_W-1:0] OP_LH  = 4'h1;
    localparam logic [OP_W-1:0] OP_LW  = 4'h2;
    localparam logic [OP_W-1:0] OP_LBU = 4'h4;
    localparam logic [OP_W-1:0] OP_LHU = 4'h5;
    localparam logic [OP_W-1:0] OP_SB  = 4'h8;
    localparam logic [OP_W-1:0] OP_SH  = 4'h9;
    localparam logic [OP_W-1:0] OP_SW  = 4'hA;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [1:0]           off_q;

    logic                 dec_legal;
    logic                 dec_we;
    logic                 dec_uns;
    logic [1:0]           dec_size;
    logic                 dec_misalign;
    logic [3:0]           dec_be;
    logic [DATA_WIDTH-1:0] dec_wdata;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;

    // Decode the incoming request: size, signedness, alignment, enables and store data.
    always_comb begin
        dec_legal = 1'b1;
        dec_we    = 1'b0;
        dec_uns   = 1'b0;
        dec_size  = SZ_W;
        case (lsu_opcode_i)
            OP_LB:  dec_size = SZ_B;
            OP_LH:  dec_size = SZ_H;
            OP_LW:  dec_size = SZ_W;
            OP_LBU: begin dec_size = SZ_B; dec_uns = 1'b1; end
            OP_LHU: begin dec_size = SZ_H; dec_uns = 1'b1; end
            OP_SB:  begin dec_size = SZ_B; dec_we = 1'b1; end
            OP_SH:  begin dec_size = SZ_H; dec_we = 1'b1; end
            OP_SW:  begin dec_size = SZ_W; dec_we = 1'b1; end
            default: dec_legal = 1'b0;
        endcase

        dec_misalign = ((dec_size == SZ_H) && lsu_addr_i[0]) ||
                       ((dec_size == SZ_W) && (lsu_addr_i[1:0] != 2'b00));

        case (dec_size)
            SZ_B: begin
                dec_be    = 4'b0001 << lsu_addr_i[1:0];
                dec_wdata = {4{lsu_wdata_i[7:0]}};
            end
            SZ_H: begin
                dec_be    = 4'b0011 << lsu_addr_i[1:0];
                dec_wdata = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                dec_be    = 4'b1111;
                dec_wdata = lsu_wdata_i;
            end
        endcase
    end

    // Shift the addressed lane down and sign/zero-extend it to the full word.
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            SZ_B:    load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            SZ_H:    load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Access sequencer: state, timeout counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            size_q         <= SZ_W;
            uns_q          <= 1'b0;
            off_q          <= 2'b00;
            lsu_busy_o     <= 1'b0;
            lsu_done_o     <= 1'b0;
            lsu_rdata_o    <= '0;
            lsu_misalign_o <= 1'b0;
            lsu_buserr_o   <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_be_o       <= 4'b0000;
            mem_wdata_o    <= '0;
        end else begin
            lsu_done_o <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (lsu_req_i) begin
                        size_q <= dec_size;
                        uns_q  <= dec_uns;
                        off_q  <= lsu_addr_i[1:0];
                        if (dec_legal && !dec_misalign) begin
                            state_q     <= S_REQ;
                            lsu_busy_o  <= 1'b1;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= dec_we;
                            mem_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_o    <= dec_be;
                            mem_wdata_o <= dec_wdata;
                        end else begin
                            state_q        <= S_DONE;
                            lsu_done_o     <= 1'b1;
                            lsu_rdata_o    <= '0;
                            lsu_misalign_o <= dec_legal;
                            lsu_buserr_o   <= ~dec_legal;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        state_q   <= S_WAIT;
                        mem_req_o <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q        <= S_DONE;
                        lsu_busy_o     <= 1'b0;
                        lsu_done_o     <= 1'b1;
                        lsu_rdata_o    <= mem_we_o ? '0 : load_ext;
                        lsu_misalign_o <= 1'b0;
                        lsu_buserr_o   <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        state_q        <= S_DONE;
                        lsu_busy_o     <= 1'b0;
                        lsu_done_o     <= 1'b1;
                        lsu_rdata_o    <= '0;
                        lsu_misalign_o <= 1'b0;
                        lsu_buserr_o   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_lsu_ctrl.sv
// Bench for rv32im_lsu_ctrl: directed scenarios plus randomized accesses checked
// against a byte-level arithmetic reference of the load/store rules.
module tb_rv32im_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i;
    logic [3:0]  lsu_opcode_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misalign_o;
    logic        lsu_buserr_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32im_lsu_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req_i),
        .lsu_opcode_i  (lsu_opcode_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_done_o    (lsu_done_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_misalign_o(lsu_misalign_o),
        .lsu_buserr_o  (lsu_buserr_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, alignment by modulo, enables and lanes by arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output bit legal, output bit mis, output bit we,
                                  output logic [3:0] be, output logic [31:0] maddr,
                                  output logic [31:0] mwdata, output logic [31:0] rres);
        int    size;
        bit    sgn;
        int    off;
        longint v;
        legal = 1; we = 0; sgn = 0; size = 4;
        case (op)
            4'h0: begin size = 1; sgn = 1; end
            4'h1: begin size = 2; sgn = 1; end
            4'h2: size = 4;
            4'h4: size = 1;
            4'h5: size = 2;
            4'h8: begin size = 1; we = 1; end
            4'h9: begin size = 2; we = 1; end
            4'hA: begin size = 4; we = 1; end
            default: legal = 0;
        endcase
        off   = int'(addr % 4);
        mis   = legal && ((addr % size) != 0);
        be    = 4'(((1 << size) - 1) << off);
        maddr = addr - 32'(off);
        for (int i = 0; i < 4; i++) mwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
        v = longint'(rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        rres = 32'(v);
    endfunction

    // One complete access with given grant delay and response delay (delay >= TO times out).
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int gd, input int rd,
                             output logic [31:0] o_rdata, output logic [3:0] o_be,
                             output logic [31:0] o_addr, output logic [31:0] o_wdata,
                             output logic o_we, output logic o_mis, output logic o_err);
        bit legal, mis, we;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata, rres;
        model(op, addr, wdata, rdata, legal, mis, we, be, maddr, mwdata, rres);
        o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0;

        lsu_req_i    = 1'b1;
        lsu_opcode_i = op;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        step();
        lsu_req_i    = 1'b0;
        lsu_addr_i   = $urandom;
        lsu_wdata_i  = $urandom;

        if (!legal || mis) begin
            chk({tag, "_err_done"}, 32'(lsu_done_o), 32'd1);
            chk({tag, "_err_noreq"}, 32'(mem_req_o), 32'd0);
            chk({tag, "_err_busy"}, 32'(lsu_busy_o), 32'd0);
            chk({tag, "_err_mis"}, 32'(lsu_misalign_o), 32'(mis));
            chk({tag, "_err_buserr"}, 32'(lsu_buserr_o), 32'(!legal));
            chk({tag, "_err_rdata"}, lsu_rdata_o, 32'h0);
        end else begin
            o_be = mem_be_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o; o_we = mem_we_o;
            chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
            chk({tag, "_busy"}, 32'(lsu_busy_o), 32'd1);
            chk({tag, "_addr"}, mem_addr_o, maddr);
            chk({tag, "_be"}, 32'(mem_be_o), 32'(be));
            chk({tag, "_we"}, 32'(mem_we_o), 32'(we));
            if (we) chk({tag, "_wdata"}, mem_wdata_o, mwdata);
            for (int g = 0; g < gd; g++) begin
                step();
                chk({tag, "_req_hold"}, 32'(mem_req_o), 32'd1);
                chk({tag, "_addr_hold"}, mem_addr_o, maddr);
                chk({tag, "_be_hold"}, 32'(mem_be_o), 32'(be));
                chk({tag, "_nodone_gnt"}, 32'(lsu_done_o), 32'd0);
            end
            mem_gnt_i = 1'b1;
            step();
            mem_gnt_i = 1'b0;
            chk({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
            chk({tag, "_busy_wait"}, 32'(lsu_busy_o), 32'd1);
            if (rd + 1 <= int'(TO)) begin
                for (int r = 0; r < rd; r++) begin
                    step();
                    chk({tag, "_nodone_rv"}, 32'(lsu_done_o), 32'd0);
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rdata;
                step();
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = $urandom;
                chk({tag, "_done"}, 32'(lsu_done_o), 32'd1);
                chk({tag, "_busy_done"}, 32'(lsu_busy_o), 32'd0);
                chk({tag, "_mis"}, 32'(lsu_misalign_o), 32'd0);
                chk({tag, "_buserr"}, 32'(lsu_buserr_o), 32'd0);
                if (!we) chk({tag, "_rdata"}, lsu_rdata_o, rres);
            end else begin
                for (int r = 0; r < int'(TO) - 1; r++) begin
                    step();
                    chk({tag, "_nodone_to"}, 32'(lsu_done_o), 32'd0);
                end
                step();
                chk({tag, "_to_done"}, 32'(lsu_done_o), 32'd1);
                chk({tag, "_to_buserr"}, 32'(lsu_buserr_o), 32'd1);
                chk({tag, "_to_mis"}, 32'(lsu_misalign_o), 32'd0);
                chk({tag, "_to_rdata"}, lsu_rdata_o, 32'h0);
            end
        end
        o_rdata = lsu_rdata_o;
        o_mis   = lsu_misalign_o;
        o_err   = lsu_buserr_o;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 32'(lsu_done_o), 32'd0);
        chk({tag, "_busy"}, 32'(lsu_busy_o), 32'd0);
        chk({tag, "_rdata"}, lsu_rdata_o, 32'h0);
        chk({tag, "_mis"}, 32'(lsu_misalign_o), 32'd0);
        chk({tag, "_buserr"}, 32'(lsu_buserr_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_be"}, 32'(mem_be_o), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        logic [31:0] r_rdata, r_addr, r_wdata;
        logic [3:0]  r_be;
        logic        r_we, r_mis, r_err;
        logic [3:0]  ops [10];
        ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'h3, 4'hF};

        rst_ni = 1'b0; lsu_req_i = 1'b0; lsu_opcode_i = 4'h0; lsu_addr_i = 32'h0;
        lsu_wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        step();
        step();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        step();

        // Aligned LW, immediate grant and response.
        do_access("t1_lw", 4'h2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t1_be_const", 32'(r_be), 32'hF);
        chk("t1_addr_const", r_addr, 32'h100);
        chk("t1_rdata_const", r_rdata, 32'hDEADBEEF);
        step();
        chk("t1_done_pulse", 32'(lsu_done_o), 32'd0);
        chk("t1_rdata_hold", lsu_rdata_o, 32'hDEADBEEF);

        // Byte loads at the top lane, signed then unsigned, back to back.
        do_access("t2_lb", 4'h0, 32'h103, 32'h0, 32'h80123456, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t2_lb_be_const", 32'(r_be), 32'h8);
        chk("t2_lb_rdata_const", r_rdata, 32'hFFFFFF80);
        do_access("t2_lbu", 4'h4, 32'h103, 32'h0, 32'h80123456, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t2_lbu_rdata_const", r_rdata, 32'h00000080);

        // Halfword store to the upper half.
        do_access("t3_sh", 4'h9, 32'h202, 32'h0000ABCD, 32'h0, 0, 1,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t3_we_const", 32'(r_we), 32'd1);
        chk("t3_be_const", 32'(r_be), 32'hC);
        chk("t3_wdata_const", r_wdata, 32'hABCDABCD);

        // Misaligned accesses complete without touching the bus.
        do_access("t4_lw_mis", 4'h2, 32'h101, 32'h0, 32'h0, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t4_lw_mis_const", 32'(r_mis), 32'd1);
        do_access("t4_sh_mis", 4'h9, 32'h3, 32'h1234, 32'h0, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t4_sh_mis_const", 32'(r_mis), 32'd1);
        chk("t4_sh_rdata_const", r_rdata, 32'h0);
        step();

        // Grant withheld 5 cycles, then no response: timeout.
        do_access("t5_to", 4'h2, 32'h40, 32'h0, 32'h0, 5, 10,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t5_buserr_const", 32'(r_err), 32'd1);
        // Response in the last allowed WAIT cycle still wins.
        do_access("t5_edge", 4'h1, 32'h42, 32'h0, 32'h8001FFFF, 0, int'(TO) - 1,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t5_edge_rdata_const", r_rdata, 32'hFFFF8001);

        // Reset during WAIT, late response ignored, then a clean LW.
        lsu_req_i = 1'b1; lsu_opcode_i = 4'h2; lsu_addr_i = 32'h80;
        step();
        lsu_req_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk_all_zero("t6_rst");
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        step();
        mem_rvalid_i = 1'b0;
        chk("t6_late_done", 32'(lsu_done_o), 32'd0);
        chk("t6_late_busy", 32'(lsu_busy_o), 32'd0);
        chk("t6_late_rdata", lsu_rdata_o, 32'h0);
        do_access("t6_lw", 4'h2, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0,
                  r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
        chk("t6_rdata_const", r_rdata, 32'hCAFEF00D);

        // Randomized accesses, some back to back, some timing out.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] prev;
            do_access("rnd", ops[$urandom_range(0, 9)], $urandom & 32'h0000_0FFF, $urandom,
                      $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                      r_rdata, r_be, r_addr, r_wdata, r_we, r_mis, r_err);
            prev = r_rdata;
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rnd_done_pulse", 32'(lsu_done_o), 32'd0);
                chk("rnd_rdata_hold", lsu_rdata_o, prev);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
